// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: start, DATA_BITS LSB-first, optional parity, 1 or 2 stop bits.
// A one-word holding register lets back-to-back frames run with no idle gap.
//
// state    | meaning
// S_IDLE   | line high, waiting for the holding register to fill
// S_START  | driving the start bit (low)
// S_DATA   | driving data bits LSB-first
// S_PARITY | driving the parity bit (only when PARITY_MODE != 0)
// S_STOP   | driving stop bit(s); reloads straight into S_START when a word is held
module uart_tx_framed #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset_n,
    input  logic                 i_Tx_DV,
    input  logic [DATA_BITS-1:0] i_Tx_Byte,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx_Serial,
    output logic                 o_Tx_Active,
    output logic                 o_Tx_Done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_framed: CLKS_PER_BIT must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_tx_framed: DATA_BITS must be 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
        $error("uart_tx_framed: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_framed: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     clk_cnt, clk_cnt_nxt;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
    logic                 stop_idx, stop_idx_nxt;
    logic [DATA_BITS-1:0] shifter, shifter_nxt;
    logic [DATA_BITS-1:0] hold, hold_nxt;
    logic                 hold_full, hold_full_nxt;
    logic                 parity_bit, parity_nxt;
    logic                 serial_nxt, active_nxt, done_nxt;
    logic                 accept, bit_end, load, hold_par;

    assign accept     = i_Tx_DV && !hold_full;
    assign bit_end    = (clk_cnt == CNT_LAST);
    assign hold_par   = (PARITY_MODE == 2) ? ^hold : ~^hold;
    assign o_Tx_Ready = !hold_full;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state       <= S_IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            shifter     <= '0;
            hold        <= '0;
            hold_full   <= 1'b0;
            parity_bit  <= 1'b0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            state       <= state_nxt;
            clk_cnt     <= clk_cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            stop_idx    <= stop_idx_nxt;
            shifter     <= shifter_nxt;
            hold        <= hold_nxt;
            hold_full   <= hold_full_nxt;
            parity_bit  <= parity_nxt;
            o_Tx_Serial <= serial_nxt;
            o_Tx_Active <= active_nxt;
            o_Tx_Done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        clk_cnt_nxt  = clk_cnt;
        bit_idx_nxt  = bit_idx;
        stop_idx_nxt = stop_idx;
        shifter_nxt  = shifter;
        parity_nxt   = parity_bit;
        serial_nxt   = o_Tx_Serial;
        active_nxt   = o_Tx_Active;
        done_nxt     = 1'b0;
        load         = 1'b0;

        case (state)
            S_IDLE: begin
                serial_nxt = 1'b1;
                active_nxt = 1'b0;
                load       = hold_full;
            end
            S_START: begin
                if (bit_end) begin
                    clk_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = S_DATA;
                    serial_nxt  = shifter[0];
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    clk_cnt_nxt = '0;
                    if (bit_idx == IDX_LAST) begin
                        if (PARITY_MODE != 0) begin
                            state_nxt  = S_PARITY;
                            serial_nxt = parity_bit;
                        end else begin
                            state_nxt    = S_STOP;
                            serial_nxt   = 1'b1;
                            stop_idx_nxt = 1'b0;
                        end
                    end else begin
                        // shifter[0] is always the bit on the line
                        bit_idx_nxt = bit_idx + 1'b1;
                        shifter_nxt = shifter >> 1;
                        serial_nxt  = shifter[1];
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    clk_cnt_nxt  = '0;
                    state_nxt    = S_STOP;
                    serial_nxt   = 1'b1;
                    stop_idx_nxt = 1'b0;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    clk_cnt_nxt = '0;
                    if (STOP_BITS == 2 && !stop_idx) begin
                        stop_idx_nxt = 1'b1;
                    end else begin
                        done_nxt = 1'b1;
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_nxt  = S_IDLE;
                            active_nxt = 1'b0;
                        end
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (load) begin
            shifter_nxt = hold;
            parity_nxt  = hold_par;
            state_nxt   = S_START;
            serial_nxt  = 1'b0;
            active_nxt  = 1'b1;
            clk_cnt_nxt = '0;
        end

        // accept needs an empty hold and load needs a full one, so they never coincide
        hold_full_nxt = load ? 1'b0 : (accept ? 1'b1 : hold_full);
        hold_nxt      = accept ? i_Tx_Byte : hold;
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: five configurations, expected frames queued per instance
// and checked clock-by-clock by an independent line monitor.
module tb_uart_tx_framed;

    localparam int NI = 5;

    typedef struct {
        logic [15:0] bits;
        int          n;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NI-1:0] dv;
    logic [NI-1:0] ready, serial, active, done;
    logic [8:0]    byt [NI];
    int            cpb [NI] = '{4, 4, 4, 4, 87};
    frame_t        exp_q [NI][$];
    bit            busy [NI];
    int            cnt [NI];
    frame_t        cur [NI];
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[0]), .i_Tx_Byte(byt[0][7:0]),
        .o_Tx_Ready(ready[0]), .o_Tx_Serial(serial[0]), .o_Tx_Active(active[0]), .o_Tx_Done(done[0]));
    uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[1]), .i_Tx_Byte(byt[1][7:0]),
        .o_Tx_Ready(ready[1]), .o_Tx_Serial(serial[1]), .o_Tx_Active(active[1]), .o_Tx_Done(done[1]));
    uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2)) u_8o2 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[2]), .i_Tx_Byte(byt[2][7:0]),
        .o_Tx_Ready(ready[2]), .o_Tx_Serial(serial[2]), .o_Tx_Active(active[2]), .o_Tx_Done(done[2]));
    uart_tx_framed #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(1)) u_7n1 (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[3]), .i_Tx_Byte(byt[3][6:0]),
        .o_Tx_Ready(ready[3]), .o_Tx_Serial(serial[3]), .o_Tx_Active(active[3]), .o_Tx_Done(done[3]));
    uart_tx_framed #(.CLKS_PER_BIT(87), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_slow (
        .i_Clock(clk), .i_Reset_n(rst_n), .i_Tx_DV(dv[4]), .i_Tx_Byte(byt[4][7:0]),
        .o_Tx_Ready(ready[4]), .o_Tx_Serial(serial[4]), .o_Tx_Active(active[4]), .o_Tx_Done(done[4]));

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %0h, expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // par < 0 means no parity bit; the parity value itself is hand-computed by the caller
    task automatic push(input int k, input logic [8:0] d, input int nd, input int par, input int ns);
        frame_t f;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        f.n       = 1;
        for (int i = 0; i < nd; i++) begin
            f.bits[f.n] = d[i];
            f.n++;
        end
        if (par >= 0) begin
            f.bits[f.n] = par[0];
            f.n++;
        end
        f.n += ns;
        exp_q[k].push_back(f);
    endtask

    // Called at a negedge; holds DV until the word is accepted.
    task automatic send(input int k, input logic [8:0] d);
        int n;
        n      = 0;
        dv[k]  = 1'b1;
        byt[k] = d;
        while (!ready[k] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!ready[k]) chk("ready_timeout", k, {31'd0, ready[k]}, 1);
        @(negedge clk);
        dv[k] = 1'b0;
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < NI; k++)
            if (busy[k] || exp_q[k].size() != 0 || !ready[k]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input int ncyc);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!all_idle() && n < ncyc);
        chk("idle_timeout", 0, {31'd0, all_idle()}, 1);
        repeat (4) @(negedge clk);
    endtask

    // Line monitor: a falling line starts the next queued frame; every clock is compared.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            bit ended;
            ended = 1'b0;
            if (!rst_n) begin
                busy[k] = 1'b0;
            end else begin
                if (busy[k] && cnt[k] == cur[k].n * cpb[k]) begin
                    chk("done_pulse", k, {31'd0, done[k]}, 1);
                    busy[k] = 1'b0;
                    ended   = 1'b1;
                end
                if (!busy[k] && serial[k] == 1'b0) begin
                    if (exp_q[k].size() == 0) begin
                        chk("unexpected_start", k, {31'd0, serial[k]}, 1);
                    end else begin
                        cur[k]  = exp_q[k].pop_front();
                        busy[k] = 1'b1;
                        cnt[k]  = 0;
                    end
                end
                if (busy[k]) begin
                    chk("serial_bit", k, {31'd0, serial[k]}, {31'd0, cur[k].bits[cnt[k] / cpb[k]]});
                    chk("active_in_frame", k, {31'd0, active[k]}, 1);
                    if (!ended) chk("done_quiet", k, {31'd0, done[k]}, 0);
                    cnt[k]++;
                end else if (ended) begin
                    chk("active_drop", k, {31'd0, active[k]}, 0);
                end else begin
                    chk("idle_line", k, {29'd0, active[k], done[k], serial[k]}, 3'b001);
                end
            end
        end
    end

    initial begin
        int n;
        dv = '0;
        for (int k = 0; k < NI; k++) byt[k] = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_serial", k, {31'd0, serial[k]}, 1);
            chk("rst_ready",  k, {31'd0, ready[k]},  1);
            chk("rst_active", k, {31'd0, active[k]}, 0);
            chk("rst_done",   k, {31'd0, done[k]},   0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 0xA5
        push(0, 9'h0A5, 8, -1, 1);
        send(0, 9'h0A5);
        wait_idle(200);

        // 8E1 0x07: three ones -> parity 1; 8O2 0x07 -> parity 0, two stops
        push(1, 9'h007, 8, 1, 1);
        send(1, 9'h007);
        wait_idle(200);
        push(2, 9'h007, 8, 0, 2);
        send(2, 9'h007);
        wait_idle(200);

        // 7N1 back-to-back: second word held in DV until accepted
        push(3, 9'h041, 7, -1, 1);
        push(3, 9'h02A, 7, -1, 1);
        send(3, 9'h041);
        send(3, 9'h02A);
        chk("ready_low_while_held", 3, {31'd0, ready[3]}, 0);
        wait_idle(300);

        // One-cycle DV while not ready must be ignored
        push(3, 9'h055, 7, -1, 1);
        send(3, 9'h055);
        chk("ready_low_after_accept", 3, {31'd0, ready[3]}, 0);
        dv[3]  = 1'b1;
        byt[3] = 9'h0FF;
        @(negedge clk);
        dv[3] = 1'b0;
        chk("ready_back_after_load", 3, {31'd0, ready[3]}, 1);
        wait_idle(300);

        // Reset during data bit 3 aborts the frame
        push(0, 9'h0C3, 8, -1, 1);
        send(0, 9'h0C3);
        n = 0;
        while (serial[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 0, {31'd0, serial[0]}, 0);
        repeat (17) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_serial", 0, {31'd0, serial[0]}, 1);
        chk("abort_active", 0, {31'd0, active[0]}, 0);
        chk("abort_ready",  0, {31'd0, ready[0]},  1);
        chk("abort_done",   0, {31'd0, done[0]},   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push(0, 9'h03C, 8, -1, 1);
        send(0, 9'h03C);
        wait_idle(200);

        // 87 clocks per bit, 0x00: 783 clocks low then 87 high
        push(4, 9'h000, 8, -1, 1);
        send(4, 9'h000);
        wait_idle(2000);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
